// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: two-requester (instruction fetch / data) memory controller.
// Round-robin arbitration on ties, one bus transaction at a time, stall on
// bus_busy, abort with err after TIMEOUT wait cycles (0 = never abort).
// All outputs are registered.
// Optional build macro MEMCTRL_BYTE_EN: when defined, D stores drive the
// latched d_be onto bus_be; otherwise every access uses all-ones enables.
module mem_arb_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  bus_rd,
    output logic                  bus_wr,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_be,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_busy,
    output logic                  err
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              last_d;     // 1: D was granted last, 0: I was
    logic              gnt_d;      // current transaction belongs to D
    logic              we_q;       // current transaction is a store
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              to_hit;
    logic              grant_d;
    logic              finish;
    logic              abort;
    logic [DATA_W-1:0] cap_data;
    logic [BE_W-1:0]   store_be;

`ifdef MEMCTRL_BYTE_EN
    assign store_be = d_be;
`else
    // Word-only stores: byte enables are accepted on the port but not used.
    logic unused_be;
    assign unused_be = ^d_be;
    assign store_be  = {BE_W{1'b1}};
`endif

    // On a tie, D wins unless D was the last one served.
    assign grant_d  = d_req && (!i_req || !last_d);
    assign cnt_inc  = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign to_hit   = (TIMEOUT != 0) && (cnt_inc == TO_VAL);
    assign cap_data = (abort || we_q) ? {DATA_W{1'b0}} : bus_rdata;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state; flags the cycle a transaction completes or aborts.
    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_req || d_req) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus_busy) begin
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_RESP;
                    finish    = 1'b1;
                end
            end
            S_WAIT: begin
                // A completing bus beats the timeout in the same cycle.
                if (!bus_busy) begin
                    state_nxt = S_RESP;
                    finish    = 1'b1;
                end else if (to_hit) begin
                    state_nxt = S_RESP;
                    finish    = 1'b1;
                    abort     = 1'b1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered datapath: grant latch, bus strobes, wait counter, response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d    <= 1'b0;
            gnt_d     <= 1'b0;
            we_q      <= 1'b0;
            cnt       <= '0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        last_d    <= grant_d;
                        gnt_d     <= grant_d;
                        we_q      <= grant_d && d_we;
                        bus_addr  <= grant_d ? d_addr : i_addr;
                        bus_wdata <= grant_d ? d_wdata : {DATA_W{1'b0}};
                        bus_be    <= (grant_d && d_we) ? store_be : {BE_W{1'b1}};
                        bus_rd    <= !(grant_d && d_we);
                        bus_wr    <= grant_d && d_we;
                        cnt       <= '0;
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT:  cnt <= cnt_inc;
                S_RESP: begin
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    i_rdata <= '0;
                    d_rdata <= '0;
                    err     <= 1'b0;
                end
                default: ;
            endcase
            if (finish) begin
                bus_rd  <= 1'b0;
                bus_wr  <= 1'b0;
                i_ack   <= !gnt_d;
                d_ack   <= gnt_d;
                i_rdata <= gnt_d ? {DATA_W{1'b0}} : cap_data;
                d_rdata <= gnt_d ? cap_data : {DATA_W{1'b0}};
                err     <= abort;
            end
        end
    end

endmodule
